instr_sequencer: RTL and testbench

Fetch/decode/dispatch controller sitting directly upstream of the per-instruction execution FSMs (MOV, ADD, ...). It owns the program counter, fetches an instruction word from synchronous program ROM, decodes the opcode, and pulses the matching one-hot start line. It then waits for that unit's Done, applying PC increments and jumps the unit requests, and re-fetches. Illegal opcodes and hung units are trapped in a FAULT state.

---
 rtl/instr_sequencer_if.sv | 24 ++
 rtl/instr_sequencer.sv | 91 +++++++++
 tb/tb_instr_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: program ROM and execution-unit bus of the instruction sequencer
interface instr_sequencer_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16,
   parameter int NUM_OPS = 8
);
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_rd_en;
   logic [INSTR_W-1:0] mem_rdata;
   logic [INSTR_W-1:0] ir;
   logic [NUM_OPS-1:0] start_vec;
   logic [NUM_OPS-1:0] done_vec;
   logic               pc_inc;
   logic               jump_en;
   logic [ADDR_W-1:0]  jump_addr;
   modport master (
      output mem_addr, mem_rd_en, ir, start_vec,
      input  mem_rdata, done_vec, pc_inc, jump_en, jump_addr
   );
   modport slave (
      input  mem_addr, mem_rd_en, ir, start_vec,
      output mem_rdata, done_vec, pc_inc, jump_en, jump_addr
   );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/dispatch controller with watchdog and sticky HALT/FAULT
module instr_sequencer #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16,
   parameter int NUM_OPS = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   instr_sequencer_if.master   bus,
   output logic                busy,
   output logic                halted,
   output logic                fault,
   output logic [1:0]          fault_code
);
   localparam int AW = NUM_OPS > 1 ? $clog2(NUM_OPS) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, DECODE, DISPATCH, EXEC, HALT, FAULT} state_t;
   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [AW-1:0]     active;
   logic [WW-1:0]     wd;
   logic [3:0]        op;
   assign op           = bus.ir[INSTR_W-1 -: 4];
   assign bus.mem_addr = pc;
   // strobes default low each cycle and are raised on the edge entering FETCH/DISPATCH
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         pc            <= '0;
         bus.ir        <= '0;
         bus.start_vec <= '0;
         bus.mem_rd_en <= 1'b0;
         busy          <= 1'b0;
         halted        <= 1'b0;
         fault         <= 1'b0;
         fault_code    <= 2'b00;
         wd            <= '0;
         active        <= '0;
      end else begin
         bus.mem_rd_en <= 1'b0;
         bus.start_vec <= '0;
         case (state)
            IDLE: if (run) begin
               state         <= FETCH;
               bus.mem_rd_en <= 1'b1;
               busy          <= 1'b1;
            end
            FETCH: state <= WAIT_MEM;
            WAIT_MEM: begin
               bus.ir <= bus.mem_rdata;
               state  <= DECODE;
            end
            DECODE: if (32'(op) < NUM_OPS) begin
               state         <= DISPATCH;
               active        <= AW'(op);
               bus.start_vec <= NUM_OPS'(1) << op;
            end else if (op == 4'hF) begin
               state  <= HALT;
               busy   <= 1'b0;
               halted <= 1'b1;
            end else begin
               state      <= FAULT;
               busy       <= 1'b0;
               fault      <= 1'b1;
               fault_code <= 2'b01;
            end
            DISPATCH: begin
               wd    <= '0;
               state <= EXEC;
            end
            EXEC: begin
               wd <= wd + 1'b1;
               pc <= bus.jump_en ? bus.jump_addr : bus.pc_inc ? pc + 1'b1 : pc;
               if (bus.done_vec[active]) begin
                  state         <= run ? FETCH : IDLE;
                  bus.mem_rd_en <= run;
                  busy          <= run;
               end else if (wd == WW'(TIMEOUT - 1)) begin
                  state      <= FAULT;
                  busy       <= 1'b0;
                  fault      <= 1'b1;
                  fault_code <= 2'b10;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized and directed checks of instr_sequencer against a transaction-level model
module tb_instr_sequencer;
   localparam int N = 8;
   logic clk = 1'b0, reset = 1'b0, run = 1'b0;
   logic busy, halted, fault;
   logic [1:0] fault_code;
   logic [15:0] rom [256];
   logic [7:0] m_pc;
   int n_checks = 0, n_errors = 0;
   int res;

   instr_sequencer_if #(.ADDR_W(8), .INSTR_W(16), .NUM_OPS(N)) bus();
   instr_sequencer #(.ADDR_W(8), .INSTR_W(16), .NUM_OPS(N), .TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .run(run), .bus(bus),
      .busy(busy), .halted(halted), .fault(fault), .fault_code(fault_code)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= rom[bus.mem_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic noise;
      bus.pc_inc = 1'($urandom);
      bus.jump_en = 1'($urandom);
      bus.jump_addr = 8'($urandom);
      bus.done_vec = N'($urandom);
   endtask

   task automatic quiet;
      bus.pc_inc = 1'b0;
      bus.jump_en = 1'b0;
      bus.jump_addr = '0;
      bus.done_vec = '0;
   endtask

   task automatic do_reset;
      reset = 1'b0;
      run = 1'b0;
      noise;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      check("rst_fault", fault, 0);
      check("rst_code", fault_code, 0);
      check("rst_start", bus.start_vec, 0);
      check("rst_rd_en", bus.mem_rd_en, 0);
      check("rst_ir", bus.ir, 0);
      check("rst_addr", bus.mem_addr, 0);
      quiet;
      reset = 1'b1;
      m_pc = 8'h00;
   endtask

   // One instruction as seen from the bus: d = Done cycle within EXEC (0 = never),
   // ak/act = cycle and kind (bit0 inc, bit1 jump) of the PC request, rn = run at Done.
   // res: 0 next fetch, 1 idle, 2 halt, 3 fault, 4 no fetch seen
   task automatic do_instr(input int d, input int ak, input int act, input logic [7:0] ja,
                           input logic rn, output int r);
      int w;
      logic [15:0] ins;
      logic [3:0] op;
      logic [N-1:0] oh;
      w = 0;
      while (bus.mem_rd_en !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("fetch_seen", bus.mem_rd_en, 1);
      if (bus.mem_rd_en !== 1'b1) begin
         r = 4;
         return;
      end
      check("fetch_addr", bus.mem_addr, m_pc);
      ins = rom[m_pc];
      op = ins[15:12];
      oh = (op < N) ? N'(1) << op : '0;
      noise;
      repeat (2) begin
         @(negedge clk);
         check("rd_pulse", bus.mem_rd_en, 0);
         check("pre_start", bus.start_vec, 0);
         noise;
      end
      @(negedge clk);
      check("start_vec", bus.start_vec, oh);
      if (op == 4'hF) begin
         check("halted", halted, 1);
         check("halt_busy", busy, 0);
         r = 2;
         return;
      end
      if (op >= N) begin
         check("fault", fault, 1);
         check("fault_code", fault_code, 1);
         check("fault_busy", busy, 0);
         r = 3;
         return;
      end
      check("ir", bus.ir, ins);
      check("disp_busy", busy, 1);
      noise;
      if (d == 0) begin
         for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            check("wd_running", fault, 0);
            bus.done_vec = (N'($urandom) | N'(8'h20)) & ~oh;
            bus.pc_inc = 1'b0;
            bus.jump_en = 1'b0;
         end
         @(negedge clk);
         check("wd_fault", fault, 1);
         check("wd_code", fault_code, 2);
         check("wd_busy", busy, 0);
         r = 3;
         return;
      end
      for (int k = 1; k <= d; k++) begin
         @(negedge clk);
         check("exec_busy", busy, 1);
         check("exec_start", bus.start_vec, 0);
         check("exec_ir", bus.ir, ins);
         bus.done_vec = (N'($urandom) & ~oh) | ((k == d) ? oh : '0);
         bus.pc_inc = (k == ak) && act[0];
         bus.jump_en = (k == ak) && act[1];
         bus.jump_addr = (k == ak) ? ja : 8'($urandom);
         run = (k == d) ? rn : 1'($urandom);
      end
      if (act[1]) m_pc = ja;
      else if (act[0]) m_pc = m_pc + 8'd1;
      @(negedge clk);
      if (rn) begin
         check("next_fetch", bus.mem_rd_en, 1);
         check("next_addr", bus.mem_addr, m_pc);
         r = 0;
      end else begin
         check("idle_rd_en", bus.mem_rd_en, 0);
         check("idle_busy", busy, 0);
         check("idle_addr", bus.mem_addr, m_pc);
         r = 1;
      end
      noise;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      quiet;
      foreach (rom[a]) rom[a] = 16'h0000;
      // first instruction: start 4 cycles after IDLE exit, inc then Done
      do_reset;
      rom[0] = 16'h0123;
      run = 1'b1;
      @(negedge clk);
      check("t1_fetch", bus.mem_rd_en, 1);
      do_instr(4, 2, 1, 8'h00, 1'b1, res);
      check("t1_res", res, 0);
      // dispatch then HALT, sticky with run high
      do_reset;
      rom[0] = 16'h3000;
      rom[1] = 16'hF000;
      run = 1'b1;
      do_instr(1, 1, 1, 8'h00, 1'b1, res);
      do_instr(1, 1, 0, 8'h00, 1'b1, res);
      check("t2_res", res, 2);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         noise;
         check("t2_halted", halted, 1);
         check("t2_rd_en", bus.mem_rd_en | busy | (|bus.start_vec), 0);
      end
      check("t2_pc", bus.mem_addr, 1);
      // illegal opcode
      do_reset;
      rom[0] = 16'h9000;
      run = 1'b1;
      do_instr(1, 1, 0, 8'h00, 1'b1, res);
      check("t3_res", res, 3);
      check("t3_pc", bus.mem_addr, 0);
      repeat (5) @(negedge clk);
      check("t3_sticky", {fault, fault_code, busy}, 4'b1010);
      // watchdog timeout, then Done on the last allowed cycle
      do_reset;
      rom[0] = 16'h2000;
      rom[1] = 16'h2000;
      run = 1'b1;
      do_instr(0, 1, 0, 8'h00, 1'b1, res);
      check("t4_res", res, 3);
      do_reset;
      run = 1'b1;
      do_instr(64, 64, 1, 8'h00, 1'b1, res);
      check("t4_edge_res", res, 0);
      check("t4_edge_fault", fault, 0);
      // PC wrap and jump priority over inc
      do_reset;
      rom[0] = 16'h1000;
      rom[255] = 16'h4000;
      run = 1'b1;
      do_instr(1, 1, 2, 8'hFF, 1'b1, res);
      do_instr(3, 2, 1, 8'h00, 1'b1, res);
      check("t5_wrap", bus.mem_addr, 0);
      do_instr(2, 2, 2, 8'hFF, 1'b1, res);
      do_instr(2, 1, 3, 8'h40, 1'b1, res);
      check("t5_jump", bus.mem_addr, 8'h40);
      // reset mid-EXEC
      do_reset;
      rom[0] = 16'h1000;
      rom[5] = 16'h0AAA;
      run = 1'b1;
      do_instr(2, 2, 2, 8'h05, 1'b1, res);
      quiet;
      repeat (3) @(negedge clk);
      check("t6_start", bus.start_vec, 1);
      @(negedge clk);
      check("t6_exec_ir", bus.ir, 16'h0AAA);
      check("t6_exec_pc", bus.mem_addr, 5);
      reset = 1'b0;
      @(negedge clk);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_pc", bus.mem_addr, 0);
      check("t6_rst_start", bus.start_vec, 0);
      check("t6_rst_ir", bus.ir, 0);
      // run dropped mid-EXEC
      do_reset;
      rom[0] = 16'h5000;
      run = 1'b1;
      do_instr(3, 1, 1, 8'h00, 1'b0, res);
      check("t6_idle_res", res, 1);
      repeat (5) begin
         @(negedge clk);
         check("t6_no_fetch", bus.mem_rd_en, 0);
      end
      // randomized programs of legal opcodes
      for (int r = 0; r < 4; r++) begin
         do_reset;
         foreach (rom[a]) rom[a] = {1'b0, 3'($urandom), 12'($urandom)};
         run = 1'b1;
         for (int i = 0; i < 25; i++) begin
            int d, ak, act;
            d = $urandom_range(1, 8);
            ak = $urandom_range(1, d);
            act = $urandom_range(0, 3);
            do_instr(d, ak, act, 8'($urandom), ($urandom_range(0, 3) != 0), res);
            if (res == 1) begin
               repeat (3) begin
                  @(negedge clk);
                  check("rnd_idle", bus.mem_rd_en, 0);
               end
               run = 1'b1;
            end else if (res != 0) begin
               check("rnd_res", res, 0);
               break;
            end
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
